// File: rtl/pop_count_seq_if.sv
// Start/done handshake bundle for the sequential population counter.
// The master side issues operands and a decision mode; the slave side reports the result.
interface pop_count_seq_if #(
    parameter int WIDTH = 16
);
    localparam int CW = $clog2(2 * WIDTH + 1);

    logic             start;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] a;
    logic [1:0]       mode;
    logic [CW-1:0]    thresh;
    logic             busy;
    logic             done;
    logic [CW-1:0]    count;
    logic             enable;

    modport master (
        output start, g, a, mode, thresh,
        input  busy, done, count, enable
    );

    modport slave (
        input  start, g, a, mode, thresh,
        output busy, done, count, enable
    );
endinterface

// File: rtl/pop_count_seq.sv
// Multi-cycle population counter over two WIDTH-bit operands, CHUNK bits of each per cycle,
// with a mode-selected parity/threshold decision driving enable.
module pop_count_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic           clk,
    input  logic           rst,
    pop_count_seq_if.slave bus
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = $clog2(2 * WIDTH + 1);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] g_q;
    logic [WIDTH-1:0] a_q;
    logic [1:0]       mode_q;
    logic [CW-1:0]    thresh_q;
    logic [CW-1:0]    acc_q;
    logic [CW-1:0]    count_q;
    logic [IW-1:0]    idx_q;
    logic             busy_q;
    logic             done_q;
    logic             enable_q;

    logic [2*CHUNK-1:0] chunk_bits;
    logic [CW-1:0]      chunk_sum;
    logic [CW-1:0]      sum_d;
    logic               enable_d;

    assign chunk_bits = {g_q[idx_q*CHUNK +: CHUNK], a_q[idx_q*CHUNK +: CHUNK]};

    // One 2*CHUNK-input adder; acc never exceeds 2*WIDTH so CW bits cannot overflow.
    always_comb begin
        chunk_sum = '0;
        for (int i = 0; i < 2 * CHUNK; i++) begin
            chunk_sum = chunk_sum + CW'(chunk_bits[i]);
        end
    end

    assign sum_d = acc_q + chunk_sum;

    always_comb begin
        enable_d = 1'b0;
        case (mode_q)
            2'b00:   enable_d = sum_d[0];
            2'b01:   enable_d = ~sum_d[0];
            2'b10:   enable_d = (sum_d >= thresh_q);
            default: enable_d = (sum_d == thresh_q);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            g_q      <= '0;
            a_q      <= '0;
            mode_q   <= '0;
            thresh_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            idx_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            enable_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        g_q      <= bus.g;
                        a_q      <= bus.a;
                        mode_q   <= bus.mode;
                        thresh_q <= bus.thresh;
                        acc_q    <= '0;
                        idx_q    <= '0;
                        enable_q <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= COUNT;
                    end
                end
                COUNT: begin
                    acc_q <= sum_d;
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == IW'(N - 1)) begin
                        count_q  <= sum_d;
                        enable_q <= enable_d;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.count  = count_q;
    assign bus.enable = enable_q;
endmodule

// File: tb/tb_pop_count_seq.sv
// Bench for pop_count_seq: three parameter sets, each checked every cycle against a
// timeline model; the 16/4 instance also runs hand-computed directed cases.
module tb_pop_count_seq;
    localparam int NCFG = 3;
    localparam int CFG_W [NCFG] = '{16, 32, 8};
    localparam int CFG_C [NCFG] = '{4, 8, 8};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [NCFG-1:0]      busy_s;
    logic [NCFG-1:0]      done_s;
    logic [NCFG-1:0]      enable_s;
    logic [NCFG-1:0][6:0] count_s;
    logic [NCFG-1:0]      fin_s;

    // Stimulus for the 16/4 instance, driven by the directed sequence below.
    logic        s0_rst;
    logic        s0_start;
    logic [31:0] s0_g;
    logic [31:0] s0_a;
    logic [1:0]  s0_mode;
    logic [6:0]  s0_thresh;

    task automatic chk(input string nm, input int cfg, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cfg%0d: got %0d, expected %0d (t=%0t)", nm, cfg, act, exp, $time);
        end
    endtask

    for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
        localparam int W  = CFG_W[gi];
        localparam int C  = CFG_C[gi];
        localparam int N  = W / C;
        localparam int CW = $clog2(2 * W + 1);

        logic        d_rst;
        logic        d_start;
        logic [31:0] d_g;
        logic [31:0] d_a;
        logic [1:0]  d_mode;
        logic [6:0]  d_thresh;

        pop_count_seq_if #(.WIDTH(W)) bus ();

        assign bus.start  = d_start;
        assign bus.g      = d_g[W-1:0];
        assign bus.a      = d_a[W-1:0];
        assign bus.mode   = d_mode;
        assign bus.thresh = d_thresh[CW-1:0];

        pop_count_seq #(.WIDTH(W), .CHUNK(C)) dut (
            .clk (clk),
            .rst (d_rst),
            .bus (bus.slave)
        );

        assign busy_s[gi]   = bus.busy;
        assign done_s[gi]   = bus.done;
        assign enable_s[gi] = bus.enable;
        assign count_s[gi]  = 7'(bus.count);

        function automatic logic [6:0] popc(input logic [31:0] x, input logic [31:0] y);
            logic [31:0] m;
            m = 32'((64'd1 << W) - 64'd1);
            return 7'($countones(x & m) + $countones(y & m));
        endfunction

        function automatic logic decide(input logic [6:0] c, input logic [1:0] md, input logic [6:0] th);
            int thr;
            thr = int'(th) % (1 << CW);
            case (md)
                2'd0:    return c[0];
                2'd1:    return !c[0];
                2'd2:    return int'(c) >= thr;
                default: return int'(c) == thr;
            endcase
        endfunction

        // Timeline model: an accepted op completes N edges later and then idles one cycle.
        int unsigned t_m    = 0;
        logic        busy_m = 1'b0;
        logic        done_m = 1'b0;
        logic        en_m   = 1'b0;
        logic [6:0]  cnt_m  = '0;
        logic        en_p   = 1'b0;
        logic [6:0]  cnt_p  = '0;
        logic [31:0] g_p    = '0;
        logic [31:0] a_p    = '0;
        logic        live   = 1'b0;

        always @(posedge clk) begin
            live <= 1'b1;
            if (d_rst) begin
                t_m    <= 0;
                busy_m <= 1'b0;
                done_m <= 1'b0;
                en_m   <= 1'b0;
                cnt_m  <= '0;
            end else if (done_m) begin
                done_m <= 1'b0;
                busy_m <= 1'b0;
            end else if (busy_m) begin
                t_m <= t_m - 1;
                if (t_m == 1) begin
                    done_m <= 1'b1;
                    cnt_m  <= cnt_p;
                    en_m   <= en_p;
                    $display("cfg%0d W=%0d op g=%h a=%h -> count=%0d enable=%0d",
                             gi, W, g_p, a_p, cnt_p, en_p);
                end
            end else if (d_start) begin
                busy_m <= 1'b1;
                t_m    <= N;
                en_m   <= 1'b0;
                cnt_p  <= popc(d_g, d_a);
                en_p   <= decide(popc(d_g, d_a), d_mode, d_thresh);
                g_p    <= d_g;
                a_p    <= d_a;
            end
        end

        always @(negedge clk) begin
            if (live) begin
                chk("busy",   gi, 32'(bus.busy),   32'(busy_m));
                chk("done",   gi, 32'(bus.done),   32'(done_m));
                chk("count",  gi, 32'(bus.count),  32'(cnt_m));
                chk("enable", gi, 32'(bus.enable), 32'(en_m));
            end
        end

        if (gi == 0) begin : g_dir
            assign d_rst     = s0_rst;
            assign d_start   = s0_start;
            assign d_g       = s0_g;
            assign d_a       = s0_a;
            assign d_mode    = s0_mode;
            assign d_thresh  = s0_thresh;
            assign fin_s[gi] = 1'b1;
        end else begin : g_rnd
            logic fin = 1'b0;
            assign fin_s[gi] = fin;
            initial begin
                d_rst = 1'b1; d_start = 1'b0; d_g = '0; d_a = '0; d_mode = '0; d_thresh = '0;
                repeat (3) @(posedge clk);
                #1 d_rst = 1'b0;
                for (int k = 0; k < 600; k++) begin
                    d_start  = ($urandom_range(0, 2) == 0);
                    d_g      = (k % 17 == 0) ? 32'hFFFF_FFFF : 32'($urandom);
                    d_a      = (k % 23 == 0) ? 32'h0 : 32'($urandom);
                    d_mode   = 2'($urandom_range(0, 3));
                    d_thresh = 7'($urandom_range(0, 2 * W));
                    d_rst    = ($urandom_range(0, 99) == 0);
                    @(posedge clk);
                    #1;
                end
                d_start = 1'b0;
                d_rst   = 1'b0;
                repeat (N + 4) @(posedge clk);
                fin = 1'b1;
            end
        end
    end

    task automatic run0(input string nm, input logic [15:0] g, input logic [15:0] a,
                        input logic [1:0] md, input logic [6:0] th, input int ecnt, input logic een);
        int cyc  = 0;
        int bcnt = 0;
        int dcyc = 0;
        s0_g = {16'h0, g}; s0_a = {16'h0, a}; s0_mode = md; s0_thresh = th; s0_start = 1'b1;
        @(posedge clk);
        #1 s0_start = 1'b0;
        while (dcyc == 0 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (busy_s[0]) bcnt++;
            if (done_s[0]) dcyc = cyc;
        end
        chk({nm, "_latency"}, 0, dcyc, 5);
        chk({nm, "_busycycles"}, 0, bcnt, 5);
        chk({nm, "_count"}, 0, 32'(count_s[0]), ecnt);
        chk({nm, "_enable"}, 0, 32'(enable_s[0]), 32'(een));
        @(negedge clk);
        chk({nm, "_idle"}, 0, {30'h0, busy_s[0], done_s[0]}, 0);
    endtask

    initial begin
        int ndone;
        logic [6:0] got_cnt;
        logic got_en;
        s0_rst = 1'b1; s0_start = 1'b0; s0_g = '0; s0_a = '0; s0_mode = '0; s0_thresh = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",   0, 32'(busy_s[0]),   0);
        chk("rst_done",   0, 32'(done_s[0]),   0);
        chk("rst_count",  0, 32'(count_s[0]),  0);
        chk("rst_enable", 0, 32'(enable_s[0]), 0);
        s0_rst = 1'b0;
        @(negedge clk);

        run0("odd_bit",  16'h0001, 16'h0000, 2'b00, 7'd0,  1,  1'b1);
        run0("ones_odd", 16'hFFFF, 16'hFFFF, 2'b00, 7'd0,  32, 1'b0);
        run0("ones_evn", 16'hFFFF, 16'hFFFF, 2'b01, 7'd0,  32, 1'b1);
        run0("ge_12",    16'h00FF, 16'h000F, 2'b10, 7'd12, 12, 1'b1);
        run0("ge_13",    16'h00FF, 16'h000F, 2'b10, 7'd13, 12, 1'b0);
        run0("eq_12",    16'h00FF, 16'h000F, 2'b11, 7'd12, 12, 1'b1);

        // Second start and operand changes during COUNT must not disturb the captured op.
        s0_g = 32'h0003; s0_a = 32'h0100; s0_mode = 2'b00; s0_start = 1'b1;
        @(posedge clk);
        #1 s0_start = 1'b0;
        @(posedge clk);
        #1 s0_start = 1'b1; s0_g = 32'hFFFF; s0_a = 32'hFFFF; s0_mode = 2'b01;
        @(posedge clk);
        #1 s0_start = 1'b0;
        ndone = 0; got_cnt = '0; got_en = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done_s[0]) begin
                ndone++;
                got_cnt = count_s[0];
                got_en  = enable_s[0];
            end
        end
        chk("ignore_ndone",  0, ndone, 1);
        chk("ignore_count",  0, 32'(got_cnt), 3);
        chk("ignore_enable", 0, 32'(got_en), 1);

        // Reset during the second COUNT cycle aborts the op.
        s0_g = 32'hF0F0; s0_a = 32'h0; s0_mode = 2'b01; s0_start = 1'b1;
        @(posedge clk);
        #1 s0_start = 1'b0;
        @(posedge clk);
        #1 s0_rst = 1'b1;
        @(posedge clk);
        #1 s0_rst = 1'b0;
        @(negedge clk);
        chk("abort_busy",   0, 32'(busy_s[0]),   0);
        chk("abort_done",   0, 32'(done_s[0]),   0);
        chk("abort_count",  0, 32'(count_s[0]),  0);
        chk("abort_enable", 0, 32'(enable_s[0]), 0);
        ndone = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done_s[0]) ndone++;
        end
        chk("abort_nodone", 0, ndone, 0);
        run0("after_rst", 16'h8001, 16'h7000, 2'b00, 7'd0, 5, 1'b1);

        for (int k = 0; k < 300; k++) begin
            s0_start  = ($urandom_range(0, 2) == 0);
            s0_g      = 32'($urandom);
            s0_a      = 32'($urandom);
            s0_mode   = 2'($urandom_range(0, 3));
            s0_thresh = 7'($urandom_range(0, 32));
            s0_rst    = ($urandom_range(0, 79) == 0);
            @(posedge clk);
            #1;
        end
        s0_start = 1'b0;
        s0_rst   = 1'b0;

        for (int k = 0; k < 3000 && fin_s != 3'b111; k++) @(posedge clk);
        chk("sweep_finished", 0, 32'(fin_s), 32'(7));
        repeat (8) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pop_count_seq.md
# pop_count_seq

Parametrised, multi-cycle population counter over two WIDTH-bit operands (g, a). It adds CHUNK bits of each operand per cycle and reports the total set-bit count. A mode-selected decision (odd parity, even parity, count ≥ threshold, count == threshold) drives the enable output. It sits on the start/done control path and generalises the fixed 16-bit combinational odd-parity check to arbitrary width, selectable decision modes and a proper handshake.

## Interface
- WIDTH, 16, bits per operand; must be a multiple of CHUNK.
- CHUNK, 4, bits of each operand consumed per COUNT cycle; N = WIDTH/CHUNK.
- CW, derived = $clog2(2*WIDTH+1), count width (6 for WIDTH=16).

Ports (clock and reset first):
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request; accepted only in IDLE.
- g  in  WIDTH  operand 0, captured on accept.
- a  in  WIDTH  operand 1, captured on accept.
- mode  in  2  decision select, captured on accept: 00 odd, 01 even, 10 count≥thresh, 11 count==thresh.
- thresh  in  CW  threshold for modes 10/11, captured on accept.
- busy  out  1  high in COUNT and DONE.
- done  out  1  one-cycle pulse; count/enable valid.
- count  out  CW  total set bits in g and a.
- enable  out  1  decision result.

## Operation
- States: IDLE, COUNT, DONE.
- IDLE + start=1 at an edge:
  - capture g, a, mode and thresh into registers;
  - clear the accumulator and chunk index;
  - clear enable to 0;
  - go to COUNT.
- IDLE + start=0: stay in IDLE. count and enable hold their last values.
- COUNT, each edge:
  - acc += popcount(g_r[idx*CHUNK +: CHUNK]) + popcount(a_r[idx*CHUNK +: CHUNK]);
  - idx++.
  - The per-chunk adder is 2*CHUNK inputs wide; acc is CW bits and never overflows (max 2*WIDTH).
- COUNT with idx==N-1: the final sum is written to count, enable is written from the decision, and the state goes to DONE.
- Decision:
  - odd: enable = final_count[0];
  - even: enable = ~final_count[0];
  - ≥: enable = (final_count ≥ thresh_r);
  - ==: enable = (final_count == thresh_r).
- DONE: done=1 for exactly this cycle, then IDLE on the next edge.
- start while busy (COUNT or DONE) is ignored, not queued. Input changes on g, a, mode and thresh after accept have no effect.
- Reset at any point (including mid-COUNT): state=IDLE; busy, done, enable, count, acc and idx all become 0 on that edge. rst wins over a simultaneous start.

## Timing
- Reset values: busy=0, done=0, count=0, enable=0.
- Edge E0 samples start=1 in IDLE. busy=1 from after E0.
- COUNT occupies edges E1..EN. done=1, with count and enable valid, during the cycle after EN.
- Latency from start-sample edge to done high: N+1 cycles (5 for defaults). Occupancy: N+1 cycles; the next start is accepted at the edge ending the DONE cycle + 1 (first IDLE cycle).
- Throughput: one operation per N+2 cycles.
- count and enable are registered and stable from done until the next accepted start. enable clears at accept; count holds until overwritten.
- All outputs are registered; no combinational input-to-output path.

## Test plan
- Single odd bit: g=16'h0001, a=16'h0000, mode=00, start for one cycle. Required: busy high for 5 cycles, done pulses exactly once 5 cycles after accept, count=1, enable=1.
- All ones: g=16'hFFFF, a=16'hFFFF. Required: count=32 (6'b100000) in both runs. mode=00 gives enable=0; rerun with mode=01 gives enable=1.
- Threshold:
  - g=16'h00FF, a=16'h000F (count=12), mode=10, thresh=12 → enable=1;
  - thresh=13 → enable=0;
  - mode=11, thresh=12 → enable=1.
- Busy-ignore and operand stability: start a run, pulse start again and change g/a during COUNT. Required: only one done, with the result of the originally captured operands; the second start produces no operation.
- Reset mid-op: assert rst on the 2nd COUNT cycle. Required: next cycle busy=0, done=0, count=0, enable=0, and done never fires for the aborted run. A following start runs normally.
- Parameter sweep: WIDTH=32, CHUNK=8 (N=4) and WIDTH=8, CHUNK=8 (N=1). Random g/a must match a software popcount. done latency is N+1 in each case.
